// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared memory/ALU datapath.
// The controller takes the master side; the datapath (instruction register, ALU) takes the slave side.
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 4
);
    logic [3:0]           Cond;
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic [3:0]           ALUFlags;

    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 mov_selec;
    logic                 PCWrite;
    logic                 RegWrite;
    logic                 MemWrite;
    logic [3:0]           Flags;
    logic [3:0]           State;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
               ALUControl, mov_selec, PCWrite, RegWrite, MemWrite, Flags, State
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
               ALUControl, mov_selec, PCWrite, RegWrite, MemWrite, Flags, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: steps each instruction through an FSM, keeps the
// NZCV register and gates every architectural write with the condition field.
module multicycle_controller #(
    parameter int       ALUCTRL_W = 4,
    parameter bit [3:0] FLAG_RST  = 4'b0000,
    parameter bit       HAS_COND  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_ORR = 4'b0110;
    localparam logic [3:0] ALU_EOR = 4'b0111;
    localparam logic [3:0] ALU_MOV = 4'b1000;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] flags;
    logic       cond_raw;
    logic       cond_ex;

    logic [3:0] alu_ctrl;
    logic       alu_known;
    logic       alu_writes;
    logic       alu_mov;
    logic       in_exec;
    logic       flag_we;

    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       mov_sel;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] imm_src;

    logic n_flag, z_flag, c_flag, v_flag;
    assign {n_flag, z_flag, c_flag, v_flag} = flags;

    // Condition evaluation against the registered flags; 1111 behaves as "never".
    always_comb begin
        cond_raw = 1'b0;
        case (bus.Cond)
            4'b0000: cond_raw = z_flag;
            4'b0001: cond_raw = ~z_flag;
            4'b0010: cond_raw = c_flag;
            4'b0011: cond_raw = ~c_flag;
            4'b0100: cond_raw = n_flag;
            4'b0101: cond_raw = ~n_flag;
            4'b0110: cond_raw = v_flag;
            4'b0111: cond_raw = ~v_flag;
            4'b1000: cond_raw = c_flag & ~z_flag;
            4'b1001: cond_raw = ~c_flag | z_flag;
            4'b1010: cond_raw = (n_flag == v_flag);
            4'b1011: cond_raw = (n_flag != v_flag);
            4'b1100: cond_raw = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_raw = z_flag | (n_flag != v_flag);
            4'b1110: cond_raw = 1'b1;
            default: cond_raw = 1'b0;
        endcase
    end

    assign cond_ex = HAS_COND ? cond_raw : 1'b1;

    // Data-processing decode; unknown commands fall back to ADD with no register or flag write.
    always_comb begin
        alu_ctrl   = ALU_ADD;
        alu_known  = 1'b1;
        alu_writes = 1'b1;
        alu_mov    = 1'b0;
        case (bus.Funct[4:1])
            4'b0100: alu_ctrl = ALU_ADD;
            4'b0010: alu_ctrl = ALU_SUB;
            4'b0000: alu_ctrl = ALU_AND;
            4'b1100: alu_ctrl = ALU_ORR;
            4'b0001: alu_ctrl = ALU_EOR;
            4'b1101: begin
                alu_mov  = 1'b1;
                alu_ctrl = bus.Funct[5] ? ALU_ADD : ALU_MOV;
            end
            4'b1010: begin
                alu_ctrl   = ALU_SUB;
                alu_writes = 1'b0;
            end
            4'b1011: begin
                alu_ctrl   = ALU_ADD;
                alu_writes = 1'b0;
            end
            4'b1000: begin
                alu_ctrl   = ALU_AND;
                alu_writes = 1'b0;
            end
            default: begin
                alu_ctrl   = ALU_ADD;
                alu_known  = 1'b0;
                alu_writes = 1'b0;
            end
        endcase
    end

    assign in_exec = (state == S_EXECR) || (state == S_EXECI);
    assign flag_we = in_exec && bus.Funct[0] && cond_ex && alu_known;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = alu_writes ? S_ALUWB : S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // C and V only move for arithmetic ops; logical ops leave them as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= FLAG_RST;
        end else if (flag_we) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB)) begin
                flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        mov_sel     = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            S_MEMRD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            S_EXECR,
            S_EXECI: begin
                alu_src_b   = (state == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = alu_ctrl;
                mov_sel     = alu_mov;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = cond_ex;
                pc_write   = cond_ex && (bus.Rd == 4'd15);
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.Op)
            2'b01:   imm_src = 2'b01;
            2'b10:   imm_src = 2'b10;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        bus.ALUControl      = '0;
        bus.ALUControl[3:0] = alu_control;
    end

    // Write enables are forced low while reset is held so nothing leaks out of FETCH.
    assign bus.IRWrite   = ir_write & rst_n;
    assign bus.PCWrite   = pc_write & rst_n;
    assign bus.RegWrite  = reg_write & rst_n;
    assign bus.MemWrite  = mem_write & rst_n;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.mov_selec = mov_sel;
    assign bus.ImmSrc    = imm_src;
    assign bus.RegSrc    = {(bus.Op == 2'b01) & ~bus.Funct[0], (bus.Op == 2'b10)};
    assign bus.Flags     = flags;
    assign bus.State     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks representative instructions
// through the FSM and compares outputs against hand-computed values.
module tb_multicycle_controller;

    logic clk;
    logic rst_n;
    int   check_count;
    int   error_count;

    multicycle_controller_if #(.ALUCTRL_W(4)) bus ();

    multicycle_controller #(
        .ALUCTRL_W(4),
        .FLAG_RST (4'b0000),
        .HAS_COND (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] cond, input logic [1:0] op,
                                 input logic [5:0] funct, input logic [3:0] rd,
                                 input logic [3:0] alu_flags);
        bus.Cond     = cond;
        bus.Op       = op;
        bus.Funct    = funct;
        bus.Rd       = rd;
        bus.ALUFlags = alu_flags;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wens();
        return {28'd0, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
    endfunction

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n = 1'b0;
        // LDR R2, AL
        applyStimulus(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
        tick();
        tick();
        checkOutput("rst_state", bus.State, 4'd0);
        checkOutput("rst_flags", bus.Flags, 4'b0000);
        checkOutput("rst_wens", wens(), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("fetch_state", bus.State, 4'd0);
        checkOutput("fetch_irwrite", bus.IRWrite, 1'b1);
        checkOutput("fetch_pcwrite", bus.PCWrite, 1'b1);
        checkOutput("fetch_alusrcb", bus.ALUSrcB, 2'b10);

        tick();
        checkOutput("ldr_s1", bus.State, 4'd1);
        checkOutput("ldr_s1_regw", bus.RegWrite, 1'b0);
        tick();
        checkOutput("ldr_s2", bus.State, 4'd2);
        checkOutput("ldr_s2_srcb", bus.ALUSrcB, 2'b01);
        checkOutput("ldr_immsrc", bus.ImmSrc, 2'b01);
        checkOutput("ldr_regsrc", bus.RegSrc, 2'b00);
        tick();
        checkOutput("ldr_s3", bus.State, 4'd3);
        checkOutput("ldr_s3_adrsrc", bus.AdrSrc, 1'b1);
        checkOutput("ldr_s3_regw", bus.RegWrite, 1'b0);
        tick();
        checkOutput("ldr_s4", bus.State, 4'd4);
        checkOutput("ldr_s4_regw", bus.RegWrite, 1'b1);
        checkOutput("ldr_s4_ressrc", bus.ResultSrc, 2'b01);
        tick();
        checkOutput("ldr_done", bus.State, 4'd0);

        // SUBS R3, AL with ALU reporting Z
        applyStimulus(4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0100);
        tick();
        tick();
        checkOutput("subs_execr", bus.State, 4'd6);
        checkOutput("subs_aluctl", bus.ALUControl, 4'b0001);
        tick();
        checkOutput("subs_aluwb", bus.State, 4'd8);
        checkOutput("subs_flags", bus.Flags, 4'b0100);
        checkOutput("subs_wb_wens", wens(), 32'h2);
        tick();
        checkOutput("subs_done", bus.State, 4'd0);

        // BEQ taken
        applyStimulus(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        tick();
        tick();
        checkOutput("beq_state", bus.State, 4'd9);
        checkOutput("beq_pcwrite", bus.PCWrite, 1'b1);
        checkOutput("beq_regsrc", bus.RegSrc, 2'b01);
        checkOutput("beq_immsrc", bus.ImmSrc, 2'b10);
        tick();
        checkOutput("beq_done", bus.State, 4'd0);

        // BNE not taken
        applyStimulus(4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000);
        tick();
        tick();
        checkOutput("bne_state", bus.State, 4'd9);
        checkOutput("bne_pcwrite", bus.PCWrite, 1'b0);
        tick();

        // CMP immediate: three cycles, no ALUWB
        applyStimulus(4'b1110, 2'b00, 6'b110101, 4'd0, 4'b1000);
        tick();
        tick();
        checkOutput("cmp_execi", bus.State, 4'd7);
        checkOutput("cmp_regw", bus.RegWrite, 1'b0);
        checkOutput("cmp_aluctl", bus.ALUControl, 4'b0001);
        tick();
        checkOutput("cmp_done", bus.State, 4'd0);
        checkOutput("cmp_flags", bus.Flags, 4'b1000);

        // ADD PC, AL
        applyStimulus(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0110);
        tick();
        tick();
        tick();
        checkOutput("addpc_aluwb", bus.State, 4'd8);
        checkOutput("addpc_wens", wens(), 32'h6);
        checkOutput("addpc_flags", bus.Flags, 4'b1000);
        tick();

        // ADDEQ PC with Z clear: suppressed
        applyStimulus(4'b0000, 2'b00, 6'b001000, 4'd15, 4'b0000);
        tick();
        tick();
        tick();
        checkOutput("addeq_aluwb", bus.State, 4'd8);
        checkOutput("addeq_wens", wens(), 32'h0);
        tick();

        // MOV immediate
        applyStimulus(4'b1110, 2'b00, 6'b111010, 4'd4, 4'b0000);
        tick();
        tick();
        checkOutput("mov_execi", bus.State, 4'd7);
        checkOutput("mov_sel", bus.mov_selec, 1'b1);
        checkOutput("mov_aluctl", bus.ALUControl, 4'b0000);
        tick();
        checkOutput("mov_aluwb", bus.State, 4'd8);
        tick();

        // Unsupported DP command with S set: no write, no flag change
        applyStimulus(4'b1110, 2'b00, 6'b000111, 4'd4, 4'b1111);
        tick();
        tick();
        checkOutput("bad_aluctl", bus.ALUControl, 4'b0000);
        tick();
        checkOutput("bad_done", bus.State, 4'd0);
        checkOutput("bad_flags", bus.Flags, 4'b1000);

        // STR interrupted by reset in MEMWR
        applyStimulus(4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000);
        tick();
        tick();
        tick();
        checkOutput("str_memwr", bus.State, 4'd5);
        checkOutput("str_memwrite", bus.MemWrite, 1'b1);
        checkOutput("str_regsrc", bus.RegSrc, 2'b10);
        rst_n = 1'b0;
        #1;
        checkOutput("str_rst_memwrite", bus.MemWrite, 1'b0);
        checkOutput("str_rst_state", bus.State, 4'd0);
        checkOutput("str_rst_flags", bus.Flags, 4'b0000);
        tick();
        checkOutput("str_rst_hold", wens(), 32'h0);
        rst_n = 1'b1;
        #1;

        // Op=11 returns to FETCH after DECODE with no writes
        applyStimulus(4'b1110, 2'b11, 6'b000000, 4'd1, 4'b0000);
        tick();
        checkOutput("op11_decode", bus.State, 4'd1);
        checkOutput("op11_wens", wens(), 32'h0);
        tick();
        checkOutput("op11_done", bus.State, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle ARM control decoder.
- Sequences each instruction through an FSM, one architectural step per clk.
- Holds the NZCV flag register and evaluates the 4-bit condition field, so writes are conditionally executed.
- Sits between the instruction register and the shared memory/ALU datapath; drives all datapath mux selects and write enables.

Parameters:
ALUCTRL_W, 4, ALUControl width (>=4); encodings zero-extended to this width
FLAG_RST, 4'b0000, NZCV value loaded on reset
HAS_COND, 1, 1 = honour Cond field; 0 = every instruction executes as AL

Ports:
clk  in  1  system clock
rst_n  in  1  reset
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  NZCV from ALU, current cycle
IRWrite  out  1  load instruction register
AdrSrc  out  1  0=PC, 1=ALU result to memory address
ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALU direct
ALUSrcA  out  1  0=RegA, 1=PC
ALUSrcB  out  2  00 RegB, 01 ExtImm, 10 constant 4
ImmSrc  out  2  immediate extend type (00 DP, 01 mem, 10 branch)
RegSrc  out  2  register-address muxes (bit0 branch, bit1 STR)
ALUControl  out  ALUCTRL_W  ALU operation
mov_selec  out  1  select MOV/shift path
PCWrite  out  1  PC enable
RegWrite  out  1  register file write enable
MemWrite  out  1  data memory write enable
Flags  out  4  registered NZCV
State  out  4  current FSM state (debug)

Behaviour:
- Reset:
  - One clk; reset is asynchronous and active-low (rst_n).
  - On rst_n=0: State=FETCH, Flags=FLAG_RST, all write enables 0.
  - Reset mid-instruction abandons the instruction with no writes.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10-15 go to FETCH next cycle with no writes.
- FETCH:
  - Outputs: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional).
  - Next: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Next by Op: 01 -> MEMADR; 00 with Funct[5]=1 -> EXECI; 00 with Funct[5]=0 -> EXECR; 10 -> BRANCH; 11 -> FETCH (unimplemented, no writes).
- MEMADR:
  - Outputs: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - Next: Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next: FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx. Next: FETCH.
- EXECR/EXECI:
  - Outputs: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI), ALU decode active.
  - Next: ALUWB if the op writes a register, else FETCH.
- ALUWB:
  - Outputs: ResultSrc=00, RegWrite=CondEx.
  - If Rd=15 then PCWrite=CondEx.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
  - Next: FETCH.
- ALU decode on Funct[4:1]:
  - Writes register: 0100 ADD->0000; 0010 SUB->0001; 0000 AND->0101; 1100 ORR->0110; 0001 EOR->0111; 1101 MOV -> mov_selec=1, ALUControl 0000 if Funct[5] else 1000.
  - No register write: 1010 CMP->0001; 1011 CMN->0000; 1000 TST->0101.
  - Any other code: ALUControl=0, no register write, no flag write (never X).
- Flags:
  - Updated on the clk edge ending EXECR/EXECI, only if Funct[0]=1 and CondEx=1.
  - N,Z always load from ALUFlags[3:2].
  - C,V load from ALUFlags[1:0] only for ALUControl 0000/0001; otherwise hold.
  - No other state modifies Flags.
- CondEx:
  - Combinational from Cond and the registered Flags; full ARM set EQ..AL (0000-1110).
  - 1111 is treated as never.
  - HAS_COND=0 forces CondEx=1.
- Fixed per-instruction outputs:
  - ImmSrc: 00 DP, 01 mem, 10 branch.
  - RegSrc = {Op==01 & ~Funct[0], Op==10}.
  - Both are held across every state of that instruction.
- Cycle counts: LDR 5, STR 4, DP with write 4, CMP/TST/CMN 3, B 3.

Test Plan:
- Hold rst_n=0 two cycles, release -> State=0, Flags=0000, IRWrite=1 in first cycle, PCWrite=1.
- LDR (Op=01, Funct=011001, Cond=1110) -> states 0,1,2,3,4; RegWrite=1 only in MEMWB; ResultSrc=01.
- SUBS then BEQ: SUBS Funct=000101 with ALUFlags=0100 -> Flags=0100 after EXECR. Then Op=10, Cond=0000 -> PCWrite=1 in BRANCH. Repeat with Cond=0001 -> PCWrite=0.
- CMP imm (Funct=110101), ALUFlags=1000 -> Flags=1000; no ALUWB state; RegWrite never 1; 3 cycles.
- ADD with Rd=15, Cond=1110 -> ALUWB asserts RegWrite=1 and PCWrite=1. Same with Cond=0000 and Z=0 -> both 0.
- Assert rst_n=0 mid-MEMWR -> MemWrite drops immediately, State=0. Also Op=11 -> FETCH after DECODE with no write enables.
